nco_prerotator: RTL and testbench
=================================

NCO_PREROTATOR -- requirements
Module: nco_prerotator

Interface
REQ-001 SHALL have parameter BW, default 12, meaning I/Q sample width (signed).
REQ-002 SHALL have parameter ABW, default 12, meaning angle width of z_o (signed).
REQ-003 SHALL have parameter PHASE_W, default 24, meaning phase accumulator width (unsigned, full scale = 2*pi).
REQ-004 SHALL have port: clk  in  1  single clock, all logic rising-edge.
REQ-005 SHALL have port: rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port: fcw  in  PHASE_W  frequency control word (unsigned phase increment).
REQ-007 SHALL have port: fcw_load  in  1  capture fcw into internal register.
REQ-008 SHALL have port: phase_clr  in  1  clear phase accumulator.
REQ-009 SHALL have port: s_valid  in  1  input sample valid.
REQ-010 SHALL have port: s_ready  out  1  input sample accepted when s_valid & s_ready.
REQ-011 SHALL have port: x_i, y_i  in  BW each  signed I/Q input.
REQ-012 SHALL have port: m_valid  out  1  output sample valid.
REQ-013 SHALL have port: m_ready  in  1  downstream accepts when m_valid & m_ready.
REQ-014 SHALL have port: x_o, y_o  out  BW each  quadrant-folded I/Q, feeds the derotator chain.
REQ-015 SHALL have port: z_o  out  ABW  residual first-quadrant angle, feeds the derotator chain.

Function
REQ-016 Accumulator acc (PHASE_W) SHALL update only on input accept: acc_next = base + fcw_r, modulo 2^PHASE_W, where base = 0 if phase_clr else acc.
REQ-017 Sample phase p attached to an accepted sample SHALL be base (phase_clr in same cycle -> p = 0).
REQ-018 phase_clr without accept SHALL set acc to 0.
REQ-019 fcw_load SHALL set fcw_r <= fcw; the sample accepted in the same cycle uses the old fcw_r.
REQ-020 Quadrant q = p[PHASE_W-1:PHASE_W-2]; fold (derotate by -q*pi/2): q0 (x,y); q1 (y,-x); q2 (-x,-y); q3 (-y,x).
REQ-021 Negation SHALL saturate: -(-2^(BW-1)) = 2^(BW-1)-1.
REQ-022 z_o SHALL be {2'b00, p[PHASE_W-3 -: ABW-2]} (truncation), scale pi = 2^(ABW-1), range [0, pi/2).
REQ-023 Pipeline SHALL be two register stages (S1: capture sample + p; S2: fold + z); latency 2 cycles accept-to-m_valid with m_ready held high.
REQ-024 Backpressure: S2 holds while m_valid & ~m_ready; S1 advances when S2 empty or draining; s_ready = ~v1 | ~v2 | m_ready.
REQ-025 With m_ready high continuously, throughput SHALL be 1 sample/cycle, no bubbles.
REQ-026 Output data SHALL remain stable while m_valid & ~m_ready.
REQ-027 No sample SHALL be dropped or duplicated under any s_valid/m_ready pattern.

Reset
REQ-028 On rst low: acc = 0, fcw_r = 0, stage valids = 0, m_valid = 0, x_o = y_o = z_o = 0; s_ready = 1 after release.
REQ-029 Reset mid-operation SHALL discard in-flight samples; first post-reset sample gets phase 0.

Structure
REQ-030 Shared package derot_pkg SHALL hold quadrant enum (Q0..Q3), angle-scale constants (pi/2 = 2^(ABW-2)) and the saturating-negate function.
REQ-031 Sub-module phase_acc SHALL contain acc, fcw_r, clear/load logic; fold and pipeline stay in top.

Verification
REQ-032 fcw=2^(PHASE_W-2), x=100,y=0, 4 samples, m_ready=1 -> (100,0),(0,-100),(-100,0),(0,100), z_o=0 each, m_valid 2 cycles after each accept.
REQ-033 fcw=2^(PHASE_W-3) (pi/4), x=0,y=50 -> z_o alternates 0, 2^(ABW-3); q sequence 0,0,1,1,2,2,3,3.
REQ-034 x=-2^(BW-1), y=0, phase in q2 -> x_o = 2^(BW-1)-1 (saturated), y_o = 0.
REQ-035 Random s_valid and m_ready (50%), 1000 samples -> output sequence equals reference model, no loss/duplication, data stable during stall.
REQ-036 phase_clr and fcw_load asserted in same cycle as an accept -> that sample p = 0 using old fcw_r; next sample p = old fcw_r; following increment uses new fcw.
REQ-037 acc = 2^PHASE_W - fcw_r/2 then two accepts -> second sample phase wraps to fcw_r/2, q = 0.

Source files
------------

// File: rtl/derot_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// derot_pkg : quadrant type, angle-scale helpers, saturating negate
// Revision  : 1.0
// ---------------------------------------------------------------------------
package derot_pkg;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quad_e;

    localparam int QUAD_W = 2;

    // Angle scale: pi maps to 2^(abw-1), pi/2 to 2^(abw-2).
    function automatic int angle_pi(input int abw);
        return 1 << (abw - 1);
    endfunction

    function automatic int angle_half_pi(input int abw);
        return 1 << (abw - 2);
    endfunction

    // Two's-complement negate of a bw-bit value; the most negative code clips
    // to the most positive one instead of wrapping onto itself.
    function automatic int sat_neg(input int v, input int bw);
        int lim;
        lim = 1 << (bw - 1);
        if (v == -lim) begin
            return lim - 1;
        end else begin
            return -v;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/phase_acc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// phase_acc : NCO phase accumulator with registered FCW and clear
// Revision  : 1.0
// ---------------------------------------------------------------------------
module phase_acc #(
    parameter int PHASE_W = 24,
    parameter int OUT_W   = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PHASE_W-1:0] fcw_i,
    input  logic               fcw_load_i,
    input  logic               phase_clr_i,
    input  logic               accept_i,
    output logic [OUT_W-1:0]   phase_o
);

    logic [PHASE_W-1:0] acc_q, acc_d;
    logic [PHASE_W-1:0] fcw_q, fcw_d;
    logic [PHASE_W-1:0] phase_base;

    // The accepted sample carries the pre-increment phase, after any clear.
    always_comb begin
        phase_base = phase_clr_i ? '0 : acc_q;
        acc_d      = accept_i ? (phase_base + fcw_q) : phase_base;
        fcw_d      = fcw_load_i ? fcw_i : fcw_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            fcw_q <= '0;
        end else begin
            acc_q <= acc_d;
            fcw_q <= fcw_d;
        end
    end

    assign phase_o = phase_base[PHASE_W-1 -: OUT_W];

endmodule
`default_nettype wire

// File: rtl/nco_prerotator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nco_prerotator : NCO-driven quadrant fold of I/Q ahead of a CORDIC derotator
// Revision       : 1.0
// ---------------------------------------------------------------------------
module nco_prerotator
    import derot_pkg::*;
#(
    parameter int BW      = 12,
    parameter int ABW     = 12,
    parameter int PHASE_W = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PHASE_W-1:0]    fcw,
    input  logic                  fcw_load,
    input  logic                  phase_clr,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic signed [BW-1:0]  x_i,
    input  logic signed [BW-1:0]  y_i,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic signed [BW-1:0]  x_o,
    output logic signed [BW-1:0]  y_o,
    output logic [ABW-1:0]        z_o
);

    logic                 accept;
    logic                 adv2;
    logic [ABW-1:0]       phase;

    logic                 v1_q, v1_d;
    logic signed [BW-1:0] x1_q, x1_d, y1_q, y1_d;
    logic [ABW-1:0]       p1_q, p1_d;

    logic                 v2_q, v2_d;
    logic signed [BW-1:0] x2_q, x2_d, y2_q, y2_d;
    logic [ABW-1:0]       z2_q, z2_d;

    quad_e                quad;
    logic signed [BW-1:0] neg_x, neg_y, fold_x, fold_y;
    logic [ABW-1:0]       fold_z;

    assign adv2    = ~v2_q | m_ready;
    assign s_ready = ~v1_q | ~v2_q | m_ready;
    assign accept  = s_valid & s_ready;

    phase_acc #(
        .PHASE_W (PHASE_W),
        .OUT_W   (ABW)
    ) u_phase_acc (
        .clk         (clk),
        .rst         (rst),
        .fcw_i       (fcw),
        .fcw_load_i  (fcw_load),
        .phase_clr_i (phase_clr),
        .accept_i    (accept),
        .phase_o     (phase)
    );

    // Derotate by -q*pi/2 so the residual angle lies in [0, pi/2).
    always_comb begin
        quad   = quad_e'(p1_q[ABW-1 -: QUAD_W]);
        neg_x  = BW'(sat_neg(int'(x1_q), BW));
        neg_y  = BW'(sat_neg(int'(y1_q), BW));
        fold_x = x1_q;
        fold_y = y1_q;
        case (quad)
            Q1: begin
                fold_x = y1_q;
                fold_y = neg_x;
            end
            Q2: begin
                fold_x = neg_x;
                fold_y = neg_y;
            end
            Q3: begin
                fold_x = neg_y;
                fold_y = x1_q;
            end
            default: begin
                fold_x = x1_q;
                fold_y = y1_q;
            end
        endcase
        fold_z = {2'b00, p1_q[ABW-3:0]};
    end

    always_comb begin
        v1_d = s_ready ? s_valid : v1_q;
        x1_d = accept ? x_i : x1_q;
        y1_d = accept ? y_i : y1_q;
        p1_d = accept ? phase : p1_q;

        v2_d = adv2 ? v1_q : v2_q;
        x2_d = (adv2 && v1_q) ? fold_x : x2_q;
        y2_d = (adv2 && v1_q) ? fold_y : y2_q;
        z2_d = (adv2 && v1_q) ? fold_z : z2_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q <= 1'b0;
            x1_q <= '0;
            y1_q <= '0;
            p1_q <= '0;
            v2_q <= 1'b0;
            x2_q <= '0;
            y2_q <= '0;
            z2_q <= '0;
        end else begin
            v1_q <= v1_d;
            x1_q <= x1_d;
            y1_q <= y1_d;
            p1_q <= p1_d;
            v2_q <= v2_d;
            x2_q <= x2_d;
            y2_q <= y2_d;
            z2_q <= z2_d;
        end
    end

    assign m_valid = v2_q;
    assign x_o     = x2_q;
    assign y_o     = y2_q;
    assign z_o     = z2_q;

endmodule
`default_nettype wire

// File: tb/tb_nco_prerotator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_nco_prerotator : randomized + directed self-checking bench
// Revision          : 1.0
// ---------------------------------------------------------------------------
module tb_nco_prerotator;

    localparam int BW      = 12;
    localparam int ABW     = 12;
    localparam int PHASE_W = 24;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [PHASE_W-1:0]    fcw;
    logic                  fcw_load;
    logic                  phase_clr;
    logic                  s_valid;
    logic                  s_ready;
    logic signed [BW-1:0]  x_i;
    logic signed [BW-1:0]  y_i;
    logic                  m_valid;
    logic                  m_ready;
    logic signed [BW-1:0]  x_o;
    logic signed [BW-1:0]  y_o;
    logic [ABW-1:0]        z_o;

    always #5 clk = ~clk;

    nco_prerotator #(
        .BW      (BW),
        .ABW     (ABW),
        .PHASE_W (PHASE_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fcw       (fcw),
        .fcw_load  (fcw_load),
        .phase_clr (phase_clr),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .x_i       (x_i),
        .y_i       (y_i),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .x_o       (x_o),
        .y_o       (y_o),
        .z_o       (z_o)
    );

    typedef struct {int x; int y; int z; int age;} item_t;
    typedef struct {int x; int y; int z;} obs_t;

    item_t              pend_q[$];
    obs_t               log_q[$];
    logic [PHASE_W-1:0] mdl_acc;
    logic [PHASE_W-1:0] mdl_fcw;
    int                 n_vec = 0;
    int                 n_err = 0;
    int                 n_acc = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int clip(input int v);
        int hi = (1 << (BW - 1)) - 1;
        int lo = -(1 << (BW - 1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    // Rotation by -k*90 degrees, saturated, plus the in-quadrant angle.
    function automatic item_t ref_item(input logic [PHASE_W-1:0] p, input int x, input int y);
        item_t r;
        int    k = int'(p / (1 << (PHASE_W - 2)));
        case (k)
            0:       begin r.x = x;         r.y = y;         end
            1:       begin r.x = y;         r.y = clip(-x);  end
            2:       begin r.x = clip(-x);  r.y = clip(-y);  end
            default: begin r.x = clip(-y);  r.y = x;         end
        endcase
        r.z   = int'((p / (1 << (PHASE_W - ABW))) % (1 << (ABW - 2)));
        r.age = 0;
        return r;
    endfunction

    task automatic step(input bit sv, input int x, input int y, input bit clr,
                        input bit ld, input logic [PHASE_W-1:0] f, input bit mr);
        bit                 exp_valid;
        bit                 exp_ready;
        bit                 acc_now;
        logic [PHASE_W-1:0] base;
        s_valid   = sv;
        x_i       = BW'(x);
        y_i       = BW'(y);
        phase_clr = clr;
        fcw_load  = ld;
        fcw       = f;
        m_ready   = mr;
        #1;
        exp_valid = (pend_q.size() > 0) && (pend_q[0].age >= 1);
        exp_ready = (pend_q.size() < 2) || mr;
        chk("s_ready", int'(s_ready), int'(exp_ready));
        chk("m_valid", int'(m_valid), int'(exp_valid));
        if (exp_valid) begin
            chk("x_o", int'(x_o), pend_q[0].x);
            chk("y_o", int'(y_o), pend_q[0].y);
            chk("z_o", int'(z_o), pend_q[0].z);
            if (mr) log_q.push_back('{int'(x_o), int'(y_o), int'(z_o)});
        end
        acc_now = sv && exp_ready;
        @(posedge clk);
        base = clr ? '0 : mdl_acc;
        if (exp_valid && mr) void'(pend_q.pop_front());
        foreach (pend_q[i]) pend_q[i].age++;
        if (acc_now) begin
            pend_q.push_back(ref_item(base, x, y));
            n_acc++;
        end
        mdl_acc = acc_now ? base + mdl_fcw : base;
        if (ld) mdl_fcw = f;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, '0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        s_valid = 0; phase_clr = 0; fcw_load = 0; fcw = '0; m_ready = 0;
        x_i = '0; y_i = '0;
        #1;
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_s_ready", int'(s_ready), 1);
        chk("rst_x_o", int'(x_o), 0);
        chk("rst_y_o", int'(y_o), 0);
        chk("rst_z_o", int'(z_o), 0);
        pend_q.delete();
        mdl_acc = '0;
        mdl_fcw = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic chk_log(input string tag, input int idx, input int x, input int y, input int z);
        if (idx >= log_q.size()) begin
            chk({tag, "_missing"}, log_q.size(), idx + 1);
        end else begin
            chk({tag, "_x"}, log_q[idx].x, x);
            chk({tag, "_y"}, log_q[idx].y, y);
            chk({tag, "_z"}, log_q[idx].z, z);
        end
    endtask

    initial begin
        int guard;
        int rx, ry;
        @(negedge clk);
        do_reset();

        // Quarter-turn steps of a real input.
        log_q.delete();
        step(0, 0, 0, 1, 1, 24'(1 << (PHASE_W - 2)), 1);
        for (int i = 0; i < 4; i++) step(1, 100, 0, 0, 0, '0, 1);
        idle(4);
        chk("q_cnt", log_q.size(), 4);
        chk_log("q0", 0, 100, 0, 0);
        chk_log("q1", 1, 0, -100, 0);
        chk_log("q2", 2, -100, 0, 0);
        chk_log("q3", 3, 0, 100, 0);

        // Eighth-turn steps: z alternates 0 / pi/4.
        log_q.delete();
        step(0, 0, 0, 1, 1, 24'(1 << (PHASE_W - 3)), 1);
        for (int i = 0; i < 8; i++) step(1, 0, 50, 0, 0, '0, 1);
        idle(4);
        chk("e_cnt", log_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            int ex, ey;
            case (i / 2)
                0:       begin ex = 0;   ey = 50;  end
                1:       begin ex = 50;  ey = 0;   end
                2:       begin ex = 0;   ey = -50; end
                default: begin ex = -50; ey = 0;   end
            endcase
            chk_log("eighth", i, ex, ey, (i % 2) * (1 << (ABW - 3)));
        end

        // Negating the most negative code saturates.
        log_q.delete();
        step(0, 0, 0, 1, 1, 24'(1 << (PHASE_W - 1)), 1);
        step(1, -2048, 0, 0, 0, '0, 1);
        step(1, -2048, 0, 0, 0, '0, 1);
        idle(4);
        chk_log("sat", 1, 2047, 0, 0);

        // Clear + load with an accept: p=0 on old fcw, then old fcw, then new.
        log_q.delete();
        step(0, 0, 0, 1, 1, 24'(3 << 20), 1);
        step(1, 100, 0, 0, 0, '0, 1);
        step(1, 100, 0, 1, 1, 24'(1 << 20), 1);
        step(1, 100, 0, 0, 0, '0, 1);
        step(1, 100, 0, 0, 0, '0, 1);
        idle(4);
        chk_log("cl0", 1, 100, 0, 0);
        chk_log("cl1", 2, 100, 0, 768);
        chk_log("cl2", 3, 0, -100, 0);

        // Wrap: acc = 2^PW - F/2 with F = 2^21, next two phases are it and F/2.
        log_q.delete();
        step(0, 0, 0, 1, 1, 24'((1 << PHASE_W) - (1 << 20)), 1);
        step(1, 100, 0, 0, 1, 24'(1 << 21), 1);
        step(1, 100, 0, 0, 0, '0, 1);
        step(1, 100, 0, 0, 0, '0, 1);
        idle(4);
        chk_log("wrap_a", 1, 0, 100, 768);
        chk_log("wrap_b", 2, 100, 0, 256);

        // Randomized handshakes against the reference model.
        n_acc = 0;
        guard = 0;
        while (n_acc < 1000 && guard < 20000) begin
            rx = ($urandom_range(0, 7) == 0) ? -2048 : int'($urandom_range(0, 4095)) - 2048;
            ry = ($urandom_range(0, 7) == 0) ? -2048 : int'($urandom_range(0, 4095)) - 2048;
            step(bit'($urandom_range(0, 1)), rx, ry, ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 19) == 0), 24'($urandom), bit'($urandom_range(0, 1)));
            guard++;
        end
        chk("rand_accepts", n_acc, 1000);
        idle(4);
        chk("rand_drained", pend_q.size(), 0);

        // Reset while the pipe is full, then phase restarts at zero.
        step(0, 0, 0, 0, 1, 24'(1 << 22), 1);
        for (int i = 0; i < 3; i++) step(1, 7, 9, 0, 0, '0, 0);
        do_reset();
        log_q.delete();
        step(1, 100, 0, 0, 1, 24'(1 << 22), 1);
        step(1, 100, 0, 0, 0, '0, 1);
        idle(4);
        chk("post_rst_cnt", log_q.size(), 2);
        chk_log("post_rst0", 0, 100, 0, 0);
        chk_log("post_rst1", 1, 100, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
